keypad_time_entry: RTL and testbench

//  Front-end stage for the toaster controller: scans the 4x4 matrix keypad, debounces keys,

---
 rtl/toaster_pkg.sv | 58 +++++
 rtl/keypad_scanner.sv | 126 ++++++++++++
 rtl/keypad_time_entry.sv | 117 +++++++++++
 tb/tb_keypad_time_entry.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toaster_pkg.sv
// Shared types and helpers for the toaster keypad front end.
// Key codes, FSM state encodings, the matrix-index-to-key map and BCD-to-seconds conversion.
package toaster_pkg;

  typedef enum logic [3:0] {
    K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
    KA, KB, KC, KD, KSTAR, KHASH
  } key_code_t;

  typedef enum logic [1:0] {
    ENTRY,
    WRITE,
    WAIT_REL
  } entry_state_t;

  typedef enum logic {
    DB_PRESS,
    DB_RELEASE
  } deb_state_t;

  localparam int MAX_SECONDS = 599;

  // Matrix bit index is row*4 + col.
  function automatic key_code_t code_of_index(input logic [3:0] idx);
    key_code_t code;
    case (idx)
      4'd0:    code = K1;
      4'd1:    code = K2;
      4'd2:    code = K3;
      4'd3:    code = KA;
      4'd4:    code = K4;
      4'd5:    code = K5;
      4'd6:    code = K6;
      4'd7:    code = KB;
      4'd8:    code = K7;
      4'd9:    code = K8;
      4'd10:   code = K9;
      4'd11:   code = KC;
      4'd12:   code = KSTAR;
      4'd13:   code = K0;
      4'd14:   code = KHASH;
      default: code = KD;
    endcase
    return code;
  endfunction

  // Shift-and-add only: M*60 = M*64 - M*4, S1*10 = S1*8 + S1*2.
  function automatic logic [9:0] bcd_to_seconds(input logic [11:0] bcd);
    logic [9:0] m;
    logic [9:0] s1;
    logic [9:0] s0;
    m  = {6'd0, bcd[11:8]};
    s1 = {6'd0, bcd[7:4]};
    s0 = {6'd0, bcd[3:0]};
    return ((m << 6) - (m << 2)) + ((s1 << 3) + (s1 << 1)) + s0;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner and debouncer for a 4x4 active-low matrix; one key_valid pulse per clean press.
// A press is reported DEBOUNCE_N identical single-key snapshots in; no backpressure, keys are not queued.
module keypad_scanner
  import toaster_pkg::*;
#(
  parameter int SCAN_DIV   = 2000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpc,
  output logic [3:0] kpr,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row;
  logic [11:0]      partial;
  logic [15:0]      snap;
  logic [15:0]      prev_snap;
  logic             snap_vld;
  logic             slot_end;

  deb_state_t       db_state;
  deb_state_t       db_state_n;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             fire;
  logic             onehot;
  logic [3:0]       hot_idx;

  assign slot_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign kpr      = ~(4'b0001 << row);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      row      <= 2'd0;
      partial  <= '0;
      snap     <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= 1'b0;
      if (slot_end) begin
        div_cnt <= '0;
        row     <= row + 2'd1;
        case (row)
          2'd0: partial[3:0]  <= ~kpc;
          2'd1: partial[7:4]  <= ~kpc;
          2'd2: partial[11:8] <= ~kpc;
          default: begin
            snap     <= {~kpc, partial};
            snap_vld <= 1'b1;
          end
        endcase
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign onehot = (snap != 16'd0) && ((snap & (snap - 16'd1)) == 16'd0);

  always_comb begin
    hot_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) hot_idx = 4'(i);
    end
  end

  always_comb begin
    db_state_n = db_state;
    cnt_n      = stable_cnt;
    fire       = 1'b0;
    if (snap_vld) begin
      case (db_state)
        DB_PRESS: begin
          // Anything other than a single key (idle or chord) restarts the count.
          if (onehot) begin
            if ((snap == prev_snap) && (stable_cnt != '0)) cnt_n = stable_cnt + 1'b1;
            else                                            cnt_n = CNT_W'(1);
            if (cnt_n == CNT_W'(DEBOUNCE_N)) begin
              fire       = 1'b1;
              cnt_n      = '0;
              db_state_n = DB_RELEASE;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          if (snap == 16'd0) begin
            cnt_n = stable_cnt + 1'b1;
            if (cnt_n == CNT_W'(DEBOUNCE_N)) begin
              cnt_n      = '0;
              db_state_n = DB_PRESS;
            end
          end else begin
            cnt_n = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_state   <= DB_PRESS;
      stable_cnt <= '0;
      prev_snap  <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      db_state   <= db_state_n;
      stable_cnt <= cnt_n;
      key_valid  <= fire;
      if (snap_vld) prev_snap <= snap;
      if (fire)     key_code  <= code_of_index(hot_idx);
    end
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad M:SS entry, BCD-to-seconds conversion and write/write_ack handoff to the cook timer.
// Enter -> write/Time on the next edge; write holds with Time frozen until write_ack, no timeout.
module keypad_time_entry
  import toaster_pkg::*;
#(
  parameter int SCAN_DIV   = 2000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  kpc,
  output logic [3:0]  kpr,
  input  logic        write_ack,
  output logic        write,
  output logic [9:0]  Time,
  output logic        start,
  output logic        stop,
  output logic [11:0] entry_bcd,
  output logic        err
);

  logic         key_valid;
  logic [3:0]   key_code;
  key_code_t    kc;

  entry_state_t state;
  entry_state_t state_n;
  logic         write_n;
  logic [9:0]   time_n;
  logic         start_n;
  logic         stop_n;
  logic [11:0]  bcd_n;
  logic         err_n;

  keypad_scanner #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .kpc       (kpc),
    .kpr       (kpr),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign kc = key_code_t'(key_code);

  always_comb begin
    state_n = state;
    write_n = write;
    time_n  = Time;
    start_n = start;
    stop_n  = 1'b0;
    bcd_n   = entry_bcd;
    err_n   = err;

    // Start/stop act in every state so the cook can be aborted during a transfer.
    if (key_valid && (kc == KC)) start_n = 1'b1;
    if (key_valid && (kc == KD)) begin
      start_n = 1'b0;
      stop_n  = 1'b1;
    end

    case (state)
      ENTRY: begin
        if (key_valid) begin
          err_n = 1'b0;
          if (key_code <= 4'd9) begin
            bcd_n = {entry_bcd[7:0], key_code};
          end else if (kc == KSTAR) begin
            bcd_n = 12'd0;
          end else if (kc == KA) begin
            if (entry_bcd[7:4] > 4'd5) begin
              err_n = 1'b1;
            end else begin
              time_n  = bcd_to_seconds(entry_bcd);
              write_n = 1'b1;
              state_n = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (write_ack) begin
          write_n = 1'b0;
          bcd_n   = 12'd0;
          state_n = WAIT_REL;
        end
      end
      default: begin
        if (!write_ack) state_n = ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ENTRY;
      write     <= 1'b0;
      Time      <= 10'd0;
      start     <= 1'b0;
      stop      <= 1'b0;
      entry_bcd <= 12'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      write     <= write_n;
      Time      <= time_n;
      start     <= start_n;
      stop      <= stop_n;
      entry_bcd <= bcd_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboarded bench: stimulus queues expected Time/stop events, a negedge monitor checks them.
module tb_keypad_time_entry;

  localparam int KA = 10, KB = 11, KC = 12, KD = 13, KSTAR = 14, KHASH = 15;
  localparam int HOLD = 128;

  logic        clk;
  logic        reset;
  logic [3:0]  kpc;
  logic [3:0]  kpr;
  logic        write_ack;
  logic        write;
  logic [9:0]  Time;
  logic        start;
  logic        stop;
  logic [11:0] entry_bcd;
  logic        err;

  logic [15:0] pressed;
  logic        ack_en;
  int          total;
  int          passed;
  int          exp_time_q[$];
  int          stop_q[$];

  keypad_time_entry #(.SCAN_DIV(4), .DEBOUNCE_N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .kpc       (kpc),
    .kpr       (kpr),
    .write_ack (write_ack),
    .write     (write),
    .Time      (Time),
    .start     (start),
    .stop      (stop),
    .entry_bcd (entry_bcd),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kpc = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kpr[r] && pressed[r*4 + c]) kpc[c] = 1'b0;
  end

  // Timer model: acknowledges one cycle after it sees write.
  initial begin
    write_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      write_ack = ack_en && write;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic int kbit(input int k);
    case (k)
      0: return 13;  1: return 0;   2: return 1;   3: return 2;
      4: return 4;   5: return 5;   6: return 6;   7: return 8;
      8: return 9;   9: return 10;  KA: return 3;  KB: return 7;
      KC: return 11; KD: return 15; KSTAR: return 12;
      default: return 14;
    endcase
  endfunction

  task automatic press(input int k);
    pressed = 16'd1 << kbit(k);
    repeat (HOLD) @(posedge clk);
    pressed = 16'd0;
    repeat (HOLD) @(posedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents write or stop.
  initial begin
    logic       prev_write, prev_stop, stop_chk, unstable;
    logic [9:0] held_time;
    prev_write = 0; prev_stop = 0; stop_chk = 0; unstable = 0; held_time = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_write = 0; prev_stop = 0; stop_chk = 0;
      end else begin
        if (stop_chk) begin
          chk("stop_width", stop, 1'b0);
          stop_chk = 0;
        end
        if (write && !prev_write) begin
          if (exp_time_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: Time=%0d, required no write", Time);
          end else begin
            chk("write_time", Time, exp_time_q.pop_front());
          end
          held_time = Time;
          unstable  = 0;
        end else if (write && Time != held_time) begin
          unstable = 1;
        end
        if (!write && prev_write) chk("time_stable", unstable, 1'b0);
        if (stop && !prev_stop) begin
          if (stop_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_stop: stop=1, required 0");
          end else begin
            chk("stop_start", start, stop_q.pop_front());
          end
          stop_chk = 1;
        end
        prev_write = write;
        prev_stop  = stop;
      end
    end
  end

  initial begin
    total = 0; passed = 0;
    pressed = 16'd0; ack_en = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_kpr", kpr, 4'b1110);
    chk("rst_write", write, 1'b0);
    chk("rst_time", Time, 10'd0);
    chk("rst_start", start, 1'b0);
    chk("rst_stop", stop, 1'b0);
    chk("rst_bcd", entry_bcd, 12'h000);
    chk("rst_err", err, 1'b0);
    #2 reset = 1'b0;

    // 1:30 -> 90 s, acked promptly
    press(1); press(3); press(0);
    chk("bcd_130", entry_bcd, 12'h130);
    exp_time_q.push_back(90);
    press(KA);
    chk("write_done_90", write, 1'b0);
    chk("bcd_clear_90", entry_bcd, 12'h000);

    // 9:59 -> maximum 599 s
    press(9); press(5); press(9);
    exp_time_q.push_back(599);
    press(KA);
    chk("bcd_clear_599", entry_bcd, 12'h000);

    // 2:70 is rejected
    press(2); press(7); press(0); press(KA);
    chk("err_set", err, 1'b1);
    chk("bcd_kept", entry_bcd, 12'h270);
    chk("no_write", write, 1'b0);
    press(KSTAR);
    chk("err_clear", err, 1'b0);
    chk("star_clear", entry_bcd, 12'h000);

    // bouncing 5 accepted once
    for (int i = 0; i < 3; i++) begin
      pressed = 16'd1 << kbit(5);
      repeat (16) @(posedge clk);
      pressed = 16'd0;
      repeat (16) @(posedge clk);
    end
    press(5);
    chk("bounce_once", entry_bcd, 12'h005);
    press(KSTAR);

    // chord 1+4 ignored, then 4 alone accepted
    pressed = (16'd1 << kbit(1)) | (16'd1 << kbit(4));
    repeat (HOLD) @(posedge clk);
    pressed = 16'd0;
    repeat (HOLD) @(posedge clk);
    chk("chord_ignored", entry_bcd, 12'h000);
    press(4);
    chk("single_4", entry_bcd, 12'h004);
    press(KSTAR);

    // ack withheld for 10k cycles; digits ignored, write/Time held
    ack_en = 1'b0;
    press(1); press(2); press(3);
    exp_time_q.push_back(83);
    press(KA);
    press(7);
    repeat (10000) @(posedge clk);
    #1;
    chk("hold_write", write, 1'b1);
    chk("hold_time", Time, 10'd83);
    chk("hold_bcd", entry_bcd, 12'h123);
    ack_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("late_ack_write", write, 1'b0);
    chk("late_ack_bcd", entry_bcd, 12'h000);

    // start / stop
    press(KC);
    chk("start_on", start, 1'b1);
    stop_q.push_back(0);
    press(KD);
    chk("start_off", start, 1'b0);

    // reset during an unacknowledged transfer
    ack_en = 1'b0;
    press(4); press(5);
    exp_time_q.push_back(45);
    press(KA);
    chk("pre_reset_write", write, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_write", write, 1'b0);
    chk("reset_time", Time, 10'd0);
    chk("reset_bcd", entry_bcd, 12'h000);
    chk("reset_kpr", kpr, 4'b1110);
    @(posedge clk);
    #2 reset = 1'b0;
    ack_en = 1'b1;
    repeat (20) @(posedge clk);

    chk("time_q_empty", exp_time_q.size(), 0);
    chk("stop_q_empty", stop_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
